freq_sort: RTL and testbench

- Sits directly downstream of the digit-frequency counter.
- On Start it captures the ten 8-bit symbol counts and sorts them in ascending order of count. The sort is an odd-even transposition sort, one round per cycle.
- It then streams the nonzero (symbol, count) pairs over a valid/ready handshake to the Huffman tree builder.
- Ordering is stable: equal counts keep ascending symbol order.

---
 rtl/freq_sort_if.sv | 9 +
 rtl/freq_sort.sv | 91 +++++++++
 tb/tb_freq_sort.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/freq_sort_if.sv
// freq_sort_if: valid/ready stream of (symbol, count) pairs from the sorter to the tree builder.
interface freq_sort_if #(parameter int SW = 4, parameter int CW = 8);
   logic          Out_valid;
   logic          Out_ready;
   logic [SW-1:0] Out_sym;
   logic [CW-1:0] Out_cnt;
   modport master (output Out_valid, Out_sym, Out_cnt, input Out_ready);
   modport slave  (input Out_valid, Out_sym, Out_cnt, output Out_ready);
endinterface

// File: rtl/freq_sort.sv
// freq_sort: captures symbol counts, odd-even transposition sorts them (one round per cycle)
// and streams the nonzero (symbol, count) pairs in ascending, stable order.
module freq_sort #(
   parameter int NSYM = 10,
   parameter int CW   = 8,
   parameter int SW   = 4
) (
   input  logic               Clk_in,
   input  logic               nRst,
   input  logic               Start,
   input  logic [NSYM*CW-1:0] Num_in,
   output logic               Busy,
   output logic [SW-1:0]      Sym_cnt,
   output logic               Done,
   freq_sort_if.master        os
);
   localparam int RW = $clog2(NSYM);
   localparam logic [1:0] IDLE = 2'd0, SORT = 2'd1, EMIT = 2'd2, FIN = 2'd3;
   logic [1:0]    st_q, st_d;
   logic [CW-1:0] key_q [NSYM];
   logic [CW-1:0] key_d [NSYM];
   logic [SW-1:0] sym_q [NSYM];
   logic [SW-1:0] sym_d [NSYM];
   logic [RW-1:0] rnd_q, rnd_d;
   logic [SW-1:0] ptr_q, ptr_d, cnt_q, cnt_d, nz;
   assign Busy         = st_q != IDLE;
   assign Done         = st_q == FIN;
   assign Sym_cnt      = cnt_q;
   assign os.Out_valid = st_q == EMIT;
   assign os.Out_sym   = os.Out_valid ? sym_q[ptr_q] : '0;
   assign os.Out_cnt   = os.Out_valid ? key_q[ptr_q] : '0;
   always_comb begin
      st_d  = st_q;
      key_d = key_q;
      sym_d = sym_q;
      rnd_d = rnd_q;
      ptr_d = ptr_q;
      cnt_d = cnt_q;
      nz    = '0;
      for (int i = 0; i < NSYM; i++) nz = nz + SW'(|Num_in[CW*i +: CW]);
      if (st_q == IDLE) begin
         if (Start) begin
            for (int i = 0; i < NSYM; i++) begin
               key_d[i] = Num_in[CW*i +: CW];
               sym_d[i] = SW'(i);
            end
            cnt_d = nz;
            rnd_d = '0;
            st_d  = SORT;
         end
      end else if (st_q == SORT) begin
         // strict compare on disjoint adjacent pairs keeps equal counts in symbol order
         for (int j = 0; j < NSYM - 1; j++)
            if ((j % 2) == int'(rnd_q[0]) && key_q[j] > key_q[j+1]) begin
               key_d[j]   = key_q[j+1];
               key_d[j+1] = key_q[j];
               sym_d[j]   = sym_q[j+1];
               sym_d[j+1] = sym_q[j];
            end
         rnd_d = rnd_q + RW'(1);
         if (rnd_q == RW'(NSYM - 1)) begin
            ptr_d = SW'(NSYM) - cnt_q;
            st_d  = cnt_q == '0 ? FIN : EMIT;
         end
      end else if (st_q == EMIT) begin
         if (os.Out_ready) begin
            st_d  = ptr_q == SW'(NSYM - 1) ? FIN : EMIT;
            ptr_d = ptr_q == SW'(NSYM - 1) ? ptr_q : ptr_q + SW'(1);
         end
      end else begin
         st_d = IDLE;
      end
   end
   always_ff @(posedge Clk_in or negedge nRst) begin
      if (!nRst) begin
         st_q  <= IDLE;
         key_q <= '{default: '0};
         sym_q <= '{default: '0};
         rnd_q <= '0;
         ptr_q <= '0;
         cnt_q <= '0;
      end else begin
         st_q  <= st_d;
         key_q <= key_d;
         sym_q <= sym_d;
         rnd_q <= rnd_d;
         ptr_q <= ptr_d;
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: tb/tb_freq_sort.sv
// tb_freq_sort: table-driven directed vectors for freq_sort plus stall, restart and reset sequences.
module tb_freq_sort;
   logic        clk = 0, nRst = 0, Start = 0;
   logic [79:0] Num_in = '0;
   logic        Busy, Done;
   logic [3:0]  Sym_cnt;
   int          nvec = 0, nerr = 0;
   freq_sort_if ifc ();
   freq_sort dut (.Clk_in(clk), .nRst(nRst), .Start(Start), .Num_in(Num_in), .Busy(Busy),
                  .Sym_cnt(Sym_cnt), .Done(Done), .os(ifc));
   always #5 clk = ~clk;
   typedef struct packed {
      logic [79:0] num;
      logic [79:0] esym;
      logic [79:0] ecnt;
      logic [3:0]  sc;
      logic [1:0]  mode;
      logic [31:0] extra;
   } vec_t;
   vec_t vecs [7];
   function automatic logic [79:0] pk(int a0, int a1, int a2, int a3, int a4,
                                      int a5, int a6, int a7, int a8, int a9);
      int a [10];
      logic [79:0] r;
      a = '{a0, a1, a2, a3, a4, a5, a6, a7, a8, a9};
      for (int i = 0; i < 10; i++) r[8*i +: 8] = 8'(a[i]);
      return r;
   endfunction
   task automatic chk(input string name, input int act, input int exp);
      nvec++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask
   task automatic run_case(input vec_t v, input int id);
      int nt = 0, first = -1, dn = -1, pv = 0, pr = 0, ps = 0, pc = 0;
      logic rdy;
      @(negedge clk);
      Num_in = v.num;
      Start = 1;
      for (int cyc = 1; cyc <= 60 && dn < 0; cyc++) begin
         @(negedge clk);
         Start = cyc < 32 ? v.extra[cyc] : 1'b0;
         if (cyc == 1) begin
            chk($sformatf("v%0d busy_after_start", id), int'(Busy), 1);
            chk($sformatf("v%0d sym_cnt", id), int'(Sym_cnt), int'(v.sc));
         end
         rdy = v.mode == 0 ? 1'b1 : (cyc % 3) == 2;
         ifc.Out_ready = rdy;
         if (ifc.Out_valid && first < 0) first = cyc;
         if (ifc.Out_valid && pv != 0 && pr == 0) begin
            chk($sformatf("v%0d stall_sym", id), int'(ifc.Out_sym), ps);
            chk($sformatf("v%0d stall_cnt", id), int'(ifc.Out_cnt), pc);
         end
         if (ifc.Out_valid && rdy) begin
            if (nt < 10) begin
               chk($sformatf("v%0d pair%0d_sym", id, nt), int'(ifc.Out_sym), int'(v.esym[8*nt +: 4]));
               chk($sformatf("v%0d pair%0d_cnt", id, nt), int'(ifc.Out_cnt), int'(v.ecnt[8*nt +: 8]));
            end
            nt++;
         end
         pv = int'(ifc.Out_valid);
         pr = int'(rdy);
         ps = int'(ifc.Out_sym);
         pc = int'(ifc.Out_cnt);
         if (Done) begin
            dn = cyc;
            chk($sformatf("v%0d busy_at_done", id), int'(Busy), 1);
            chk($sformatf("v%0d valid_at_done", id), int'(ifc.Out_valid), 0);
         end
      end
      Start = 0;
      ifc.Out_ready = 1;
      if (dn < 0) begin
         chk($sformatf("v%0d done_timeout", id), 0, 1);
      end else begin
         chk($sformatf("v%0d transfers", id), nt, int'(v.sc));
         chk($sformatf("v%0d first_valid_cycle", id), first, v.sc == 0 ? -1 : 11);
         if (v.mode == 0) chk($sformatf("v%0d done_cycle", id), dn, 11 + int'(v.sc));
         for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("v%0d busy_after_done", id), int'(Busy), 0);
            chk($sformatf("v%0d idle_valid", id), int'(ifc.Out_valid), 0);
            chk($sformatf("v%0d idle_done", id), int'(Done), 0);
         end
      end
   endtask
   initial begin
      int nt;
      ifc.Out_ready = 1;
      vecs[0] = '{num: pk(5,0,3,3,9,0,1,255,2,0), esym: pk(6,8,2,3,0,4,7,0,0,0),
                  ecnt: pk(1,2,3,3,5,9,255,0,0,0), sc: 7, mode: 0, extra: 0};
      vecs[1] = '{num: pk(4,4,4,4,4,4,4,4,4,4), esym: pk(0,1,2,3,4,5,6,7,8,9),
                  ecnt: pk(4,4,4,4,4,4,4,4,4,4), sc: 10, mode: 0, extra: 0};
      vecs[2] = '{num: pk(0,0,0,0,0,0,0,0,0,0), esym: '0, ecnt: '0, sc: 0, mode: 0, extra: 0};
      vecs[3] = '{num: pk(5,0,3,3,9,0,1,255,2,0), esym: pk(6,8,2,3,0,4,7,0,0,0),
                  ecnt: pk(1,2,3,3,5,9,255,0,0,0), sc: 7, mode: 1, extra: 0};
      vecs[4] = '{num: pk(5,0,3,3,9,0,1,255,2,0), esym: pk(6,8,2,3,0,4,7,0,0,0),
                  ecnt: pk(1,2,3,3,5,9,255,0,0,0), sc: 7, mode: 0,
                  extra: (32'd1 << 3) | (32'd1 << 13) | (32'd1 << 18)};
      vecs[5] = '{num: pk(10,9,8,7,6,5,4,3,2,1), esym: pk(9,8,7,6,5,4,3,2,1,0),
                  ecnt: pk(1,2,3,4,5,6,7,8,9,10), sc: 10, mode: 0, extra: 0};
      vecs[6] = '{num: pk(255,255,0,0,0,0,0,0,0,1), esym: pk(9,0,1,0,0,0,0,0,0,0),
                  ecnt: pk(1,255,255,0,0,0,0,0,0,0), sc: 3, mode: 0, extra: 0};
      #12;
      chk("rst_busy", int'(Busy), 0);
      chk("rst_valid", int'(ifc.Out_valid), 0);
      chk("rst_done", int'(Done), 0);
      chk("rst_symcnt", int'(Sym_cnt), 0);
      @(negedge clk);
      nRst = 1;
      for (int i = 0; i < 7; i++) run_case(vecs[i], i);
      @(negedge clk);
      Num_in = vecs[0].num;
      Start = 1;
      nt = 0;
      for (int cyc = 1; cyc <= 40 && nt < 3; cyc++) begin
         @(negedge clk);
         Start = 0;
         if (ifc.Out_valid) nt++;
      end
      chk("rst_seq_transfers", nt, 3);
      @(posedge clk);
      #2 nRst = 0;
      #1;
      chk("midrst_busy", int'(Busy), 0);
      chk("midrst_valid", int'(ifc.Out_valid), 0);
      chk("midrst_done", int'(Done), 0);
      chk("midrst_sym", int'(ifc.Out_sym), 0);
      chk("midrst_cnt", int'(ifc.Out_cnt), 0);
      chk("midrst_symcnt", int'(Sym_cnt), 0);
      @(negedge clk);
      nRst = 1;
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         chk("post_rst_valid", int'(ifc.Out_valid), 0);
         chk("post_rst_busy", int'(Busy), 0);
      end
      run_case('{num: pk(1,2,3,4,5,6,7,8,9,10), esym: pk(0,1,2,3,4,5,6,7,8,9),
                 ecnt: pk(1,2,3,4,5,6,7,8,9,10), sc: 10, mode: 0, extra: 0}, 7);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
